// File: rtl/dmem_arb_pkg.sv
// Shared types for the dmem_arbiter slice: FSM states, latched request record, range helper.
package dmem_arb_pkg;

    localparam int NUM_PORTS  = 2;
    localparam int REQ_DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [31:0]           addr;
        logic [REQ_DATA_W-1:0] wdata;
        logic                  port;
    } dmem_req_t;

    function automatic logic addr_in_range(input logic [31:0] addr, input int addr_w);
        return (addr >> addr_w) == 32'd0;
    endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// One requester port of the data-memory arbiter: request handshake plus registered response.
interface dmem_arb_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_arb_picker.sv
// Combinational winner select; fixed priority to port 0, or round-robin when DMEM_ARB_RR_EN is defined.
module dmem_arb_picker (
    input  logic valid0_i,
    input  logic valid1_i,
`ifdef DMEM_ARB_RR_EN
    input  logic last_i,
`endif
    output logic any_o,
    output logic port_o
);

    always_comb begin
        any_o = valid0_i | valid1_i;
`ifdef DMEM_ARB_RR_EN
        if (valid0_i && valid1_i) begin
            port_o = ~last_i;
        end else begin
            port_o = ~valid0_i;
        end
`else
        port_o = ~valid0_i;
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter serialising CPU and loader accesses onto one dataMemory port.
// Round-robin tie-break is built when DMEM_ARB_RR_EN is defined, fixed priority otherwise.
//   state  | meaning
//   IDLE   | accept the picked request, or wait
//   ACCESS | drive memory from the latched request; write commits at the closing edge
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = REQ_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arb_if.slave         port0,
    dmem_arb_if.slave         port1,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_e            state_q, state_d;
    dmem_req_t         req_q, req_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_port_q, rsp_port_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              last_q, last_d;
    logic              pick_any, pick_port;
    logic              grant0, grant1;
    logic              in_range;

    dmem_arb_picker u_picker (
        .valid0_i (port0.valid),
        .valid1_i (port1.valid),
`ifdef DMEM_ARB_RR_EN
        .last_i   (last_q),
`endif
        .any_o    (pick_any),
        .port_o   (pick_port)
    );

    assign in_range = addr_in_range(req_q.addr, ADDR_W);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_valid_d = 1'b0;
        rsp_port_d  = rsp_port_q;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        last_d      = last_q;
        grant0      = 1'b0;
        grant1      = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                // ready is combinational, so it must be masked while reset is held
                if (pick_any && !reset) begin
                    grant0      = ~pick_port;
                    grant1      = pick_port;
                    req_d.we    = pick_port ? port1.we    : port0.we;
                    req_d.addr  = pick_port ? port1.addr  : port0.addr;
                    req_d.wdata = pick_port ? port1.wdata : port0.wdata;
                    req_d.port  = pick_port;
                    last_d      = pick_port;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr_o  = req_q.addr[ADDR_W-1:0];
                mem_wdata_o = req_q.wdata;
                mem_we_o    = req_q.we & in_range;
                rsp_valid_d = 1'b1;
                rsp_port_d  = req_q.port;
                rsp_err_d   = ~in_range;
                rsp_rdata_d = (in_range && !req_q.we) ? mem_rdata_i : '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_port_q  <= rsp_port_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            last_q      <= last_d;
        end
    end

    assign port0.ready     = grant0;
    assign port1.ready     = grant1;
    assign port0.rsp_valid = rsp_valid_q & ~rsp_port_q;
    assign port1.rsp_valid = rsp_valid_q &  rsp_port_q;
    assign port0.rsp_err   = port0.rsp_valid & rsp_err_q;
    assign port1.rsp_err   = port1.rsp_valid & rsp_err_q;
    assign port0.rsp_rdata = port0.rsp_valid ? rsp_rdata_q : '0;
    assign port1.rsp_rdata = port1.rsp_valid ? rsp_rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, corner sequences and randomized traffic vs a model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_arb_if #(.DATA_W(32)) p0_if ();
    dmem_arb_if #(.DATA_W(32)) p1_if ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .port0       (p0_if),
        .port1       (p1_if),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // dataMemory stand-in: synchronous write, asynchronous read
    logic [31:0] tb_mem [256];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    assign mem_rdata = tb_mem[mem_addr];

    typedef struct {bit we; bit [31:0] addr; bit [31:0] wdata;} stim_t;
    typedef struct {bit port; bit [31:0] rdata; bit err; int due;} exp_t;
    typedef struct {bit port; bit we; bit [31:0] addr; bit [31:0] wdata; bit [31:0] exp_rdata; bit exp_err;} vec_t;

    int          n_checks = 0;
    int          n_pass = 0;
    bit [31:0]   ref_mem [256];
    stim_t       sq0[$], sq1[$];
    stim_t       cur0, cur1;
    bit          act0, act1;
    exp_t        expq[$];
    bit          busy;
    bit          acc_we, acc_inr;
    bit [7:0]    acc_addr;
    bit [31:0]   acc_wdata;
    bit          last_grant = 1'b1;
    int          cyc = 0;
    int          g0_log[$];
    bit          gorder[$];
    bit [31:0]   rlog0[$], rlog1[$];
    bit          lerr0, lerr1;
    vec_t        vt[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic drive_ports();
        p0_if.valid = act0; p0_if.we = cur0.we; p0_if.addr = cur0.addr; p0_if.wdata = cur0.wdata;
        p1_if.valid = act1; p1_if.we = cur1.we; p1_if.addr = cur1.addr; p1_if.wdata = cur1.wdata;
    endtask

    // Runs queued requests; the model says who must win, when memory is touched and what comes back.
    task automatic engine(input int budget, input bit rnd);
        int        n = 0;
        bit        g0, g1, win, ev0, ev1, inr, err;
        bit [31:0] rd;
        stim_t     s;
        exp_t      e;
        while ((sq0.size() > 0 || sq1.size() > 0 || act0 || act1 || expq.size() > 0 || busy) && n < budget) begin
            @(negedge clk);
            if (!act0 && sq0.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin cur0 = sq0.pop_front(); act0 = 1'b1; end
            if (!act1 && sq1.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin cur1 = sq1.pop_front(); act1 = 1'b1; end
            drive_ports();
            #1;
            g0 = 1'b0; g1 = 1'b0; win = 1'b0;
            if (!busy && (act0 || act1)) begin
                if (act0 && act1) win = RR ? ~last_grant : 1'b0;
                else              win = !act0;
                g0 = !win; g1 = win;
            end
            if (act0 || act1 || busy) begin
                check("ready0", p0_if.ready, g0);
                check("ready1", p1_if.ready, g1);
            end
            check("mem_we", mem_we, busy && acc_we && acc_inr);
            check("mem_addr", mem_addr, busy ? acc_addr : 8'h00);
            check("mem_wdata", mem_wdata, busy ? acc_wdata : 32'h0);
            ev0 = expq.size() > 0 && expq[0].due == cyc && expq[0].port == 1'b0;
            ev1 = expq.size() > 0 && expq[0].due == cyc && expq[0].port == 1'b1;
            check("rsp0_valid", p0_if.rsp_valid, ev0);
            check("rsp1_valid", p1_if.rsp_valid, ev1);
            if (ev0 || ev1) begin
                e = expq.pop_front();
                if (ev0) begin
                    check("rsp0_rdata", p0_if.rsp_rdata, e.rdata);
                    check("rsp0_err", p0_if.rsp_err, e.err);
                    rlog0.push_back(p0_if.rsp_rdata); lerr0 = p0_if.rsp_err;
                end else begin
                    check("rsp1_rdata", p1_if.rsp_rdata, e.rdata);
                    check("rsp1_err", p1_if.rsp_err, e.err);
                    rlog1.push_back(p1_if.rsp_rdata); lerr1 = p1_if.rsp_err;
                end
            end
            busy = g0 | g1;
            if (busy) begin
                s   = win ? cur1 : cur0;
                inr = (s.addr >> 8) == 32'd0;
                err = !inr;
                rd  = 32'h0;
                if (inr && s.we) ref_mem[s.addr[7:0]] = s.wdata;
                else if (inr)    rd = ref_mem[s.addr[7:0]];
                expq.push_back('{port: win, rdata: rd, err: err, due: cyc + 2});
                acc_we = s.we; acc_inr = inr; acc_addr = s.addr[7:0]; acc_wdata = s.wdata;
                last_grant = win;
                gorder.push_back(win);
                if (win) act1 = 1'b0;
                else begin act0 = 1'b0; g0_log.push_back(cyc); end
            end
            cyc++;
            n++;
        end
        check("engine_done", (n < budget), 1);
        p0_if.valid = 1'b0;
        p1_if.valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit        first;
        stim_t     s;
        bit [31:0] a;
        for (int i = 0; i < 256; i++) begin tb_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        cur0 = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
        cur1 = cur0;
        act0 = 1'b0; act1 = 1'b0; busy = 1'b0;
        drive_ports();

        vt[0]  = '{port: 0, we: 1, addr: 32'h00,        wdata: 32'hE3A01A02, exp_rdata: 32'h0,        exp_err: 0};
        vt[1]  = '{port: 0, we: 0, addr: 32'h00,        wdata: 32'h0,        exp_rdata: 32'hE3A01A02, exp_err: 0};
        vt[2]  = '{port: 1, we: 0, addr: 32'h100,       wdata: 32'h0,        exp_rdata: 32'h0,        exp_err: 1};
        vt[3]  = '{port: 1, we: 1, addr: 32'h04,        wdata: 32'h11223344, exp_rdata: 32'h0,        exp_err: 0};
        vt[4]  = '{port: 0, we: 0, addr: 32'h04,        wdata: 32'h0,        exp_rdata: 32'h11223344, exp_err: 0};
        vt[5]  = '{port: 1, we: 1, addr: 32'h200,       wdata: 32'h55555555, exp_rdata: 32'h0,        exp_err: 1};
        vt[6]  = '{port: 1, we: 0, addr: 32'h00,        wdata: 32'h0,        exp_rdata: 32'hE3A01A02, exp_err: 0};
        vt[7]  = '{port: 0, we: 1, addr: 32'hFF,        wdata: 32'hA5A5A5A5, exp_rdata: 32'h0,        exp_err: 0};
        vt[8]  = '{port: 1, we: 0, addr: 32'hFF,        wdata: 32'h0,        exp_rdata: 32'hA5A5A5A5, exp_err: 0};
        vt[9]  = '{port: 1, we: 0, addr: 32'h80000000,  wdata: 32'h0,        exp_rdata: 32'h0,        exp_err: 1};
        vt[10] = '{port: 0, we: 1, addr: 32'h08,        wdata: 32'h0BADF00D, exp_rdata: 32'h0,        exp_err: 0};
        vt[11] = '{port: 0, we: 0, addr: 32'h08,        wdata: 32'h0,        exp_rdata: 32'h0BADF00D, exp_err: 0};

        // reset state, with a request already pending
        reset = 1'b1;
        p0_if.valid = 1'b1;
        @(negedge clk); #1;
        check("rst_ready0", p0_if.ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rsp0_valid", p0_if.rsp_valid, 0);
        check("rst_rsp1_valid", p1_if.rsp_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        p0_if.valid = 1'b0;

        foreach (vt[i]) begin
            s = '{we: vt[i].we, addr: vt[i].addr, wdata: vt[i].wdata};
            rlog0.delete(); rlog1.delete();
            if (vt[i].port) sq1.push_back(s); else sq0.push_back(s);
            engine(20, 1'b0);
            if (vt[i].port) begin
                check("vec_rsp_count", rlog1.size(), 1);
                if (rlog1.size() > 0) check("vec_rdata", rlog1[0], vt[i].exp_rdata);
                check("vec_err", lerr1, vt[i].exp_err);
            end else begin
                check("vec_rsp_count", rlog0.size(), 1);
                if (rlog0.size() > 0) check("vec_rdata", rlog0[0], vt[i].exp_rdata);
                check("vec_err", lerr0, vt[i].exp_err);
            end
        end

        // simultaneous requests; previous grant went to port 0
        gorder.delete(); rlog0.delete(); rlog1.delete();
        sq1.push_back('{we: 1'b1, addr: 32'h08, wdata: 32'h1AFFFFF9});
        sq0.push_back('{we: 1'b0, addr: 32'h08, wdata: 32'h0});
        engine(20, 1'b0);
        first = RR ? 1'b1 : 1'b0;
        check("tie_grants", gorder.size(), 2);
        if (gorder.size() == 2) check("tie_first", gorder[0], first);
        check("tie_rsp0_count", rlog0.size(), 1);
        if (rlog0.size() > 0) check("tie_rdata0", rlog0[0], RR ? 32'h1AFFFFF9 : 32'h0BADF00D);
        check("tie_rsp1_count", rlog1.size(), 1);

        // reset in the middle of a write
        sq0.push_back('{we: 1'b1, addr: 32'h04, wdata: 32'h600DCAFE});
        engine(20, 1'b0);
        @(negedge clk);
        p0_if.valid = 1'b1; p0_if.we = 1'b1; p0_if.addr = 32'h04; p0_if.wdata = 32'hDEADBEEF;
        #1 check("midrst_ready0", p0_if.ready, 1);
        @(negedge clk);
        p0_if.valid = 1'b0;
        #1 check("midrst_access_we", mem_we, 1);
        #1 reset = 1'b1;
        p1_if.valid = 1'b1; p1_if.we = 1'b0; p1_if.addr = 32'h0;
        #1;
        check("midrst_mem_we", mem_we, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mem_wdata", mem_wdata, 0);
        check("midrst_ready1", p1_if.ready, 0);
        @(negedge clk); #1;
        check("midrst_hold_ready1", p1_if.ready, 0);
        check("midrst_rsp0", p0_if.rsp_valid, 0);
        reset = 1'b0;
        p1_if.valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            check("midrst_no_rsp0", p0_if.rsp_valid, 0);
        end
        busy = 1'b0; last_grant = 1'b1; expq.delete();

        // first tie after reset goes to port 0 in either mode
        gorder.delete(); rlog0.delete(); rlog1.delete();
        sq0.push_back('{we: 1'b0, addr: 32'h04, wdata: 32'h0});
        sq1.push_back('{we: 1'b0, addr: 32'h00, wdata: 32'h0});
        engine(20, 1'b0);
        if (gorder.size() > 0) check("postrst_first", gorder[0], 0);
        check("postrst_rsp0_count", rlog0.size(), 1);
        if (rlog0.size() > 0) check("postrst_rdata0", rlog0[0], 32'h600DCAFE);
        if (rlog1.size() > 0) check("postrst_rdata1", rlog1[0], 32'hE3A01A02);

        // back-to-back reads with valid held high
        g0_log.delete(); rlog0.delete();
        sq0.push_back('{we: 1'b0, addr: 32'h00, wdata: 32'h0});
        sq0.push_back('{we: 1'b0, addr: 32'h04, wdata: 32'h0});
        sq0.push_back('{we: 1'b0, addr: 32'hFF, wdata: 32'h0});
        engine(30, 1'b0);
        check("b2b_grants", g0_log.size(), 3);
        if (g0_log.size() == 3) begin
            check("b2b_gap1", g0_log[1] - g0_log[0], 2);
            check("b2b_gap2", g0_log[2] - g0_log[1], 2);
        end
        check("b2b_rsp_count", rlog0.size(), 3);
        if (rlog0.size() == 3) begin
            check("b2b_rdata0", rlog0[0], 32'hE3A01A02);
            check("b2b_rdata1", rlog0[1], 32'h600DCAFE);
            check("b2b_rdata2", rlog0[2], 32'hA5A5A5A5);
        end

        // randomized traffic on both ports
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h00000100;
            else                           a = 32'($urandom_range(0, 255));
            s = '{we: 1'($urandom_range(0, 1)), addr: a, wdata: $urandom};
            if ($urandom_range(0, 1) == 1) sq1.push_back(s); else sq0.push_back(s);
        end
        engine(4000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
